// File: rtl/fp_alu_pkg.sv
// Shared constants, operand record and unpack/special-value helpers for the FP ALU.
// Latency: n/a (declarations and pure functions only).
// Backpressure: n/a.
package fp_alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  localparam int FLG_NV = 4;  // invalid
  localparam int FLG_DZ = 3;  // divide by zero
  localparam int FLG_OF = 2;  // overflow
  localparam int FLG_UF = 1;  // underflow
  localparam int FLG_NX = 0;  // inexact

  localparam int         H_EXP_W = 5;
  localparam int         H_MAN_W = 10;
  localparam logic [9:0] H_BIAS  = 10'd15;
  localparam int         S_EXP_W = 8;
  localparam int         S_MAN_W = 23;
  localparam logic [9:0] S_BIAS  = 10'd127;

  localparam logic [31:0] H_QNAN = 32'h0000_7E00;
  localparam logic [31:0] H_INF  = 32'h0000_7C00;
  localparam logic [31:0] S_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] S_INF  = 32'h7F80_0000;

  // expo is the unbiased exponent in 10-bit two's complement; sig carries
  // the hidden one at bit 23 and FP16 fractions are left-aligned under it.
  typedef struct packed {
    logic        sign;
    logic [9:0]  expo;
    logic [23:0] sig;
    logic        is_zero;
    logic        is_inf;
    logic        is_nan;
  } fp_operand_t;

  // Subnormals report is_zero: the unit flushes them to zero on input.
  function automatic fp_operand_t fp_unpack(input logic [31:0] v, input logic fp16);
    fp_operand_t u;
    logic [7:0]  e;
    logic [22:0] m;
    logic        e_max;
    if (fp16) begin
      u.sign = v[15];
      e      = {3'b000, v[H_MAN_W +: H_EXP_W]};
      m      = {v[H_MAN_W-1:0], 13'b0};
      e_max  = (e == 8'd31);
      u.expo = {2'b00, e} - H_BIAS;
    end else begin
      u.sign = v[31];
      e      = v[S_MAN_W +: S_EXP_W];
      m      = v[S_MAN_W-1:0];
      e_max  = (e == 8'hFF);
      u.expo = {2'b00, e} - S_BIAS;
    end
    u.sig     = {1'b1, m};
    u.is_zero = (e == 8'd0);
    u.is_inf  = e_max && (m == 23'd0);
    u.is_nan  = e_max && (m != 23'd0);
    return u;
  endfunction

  function automatic logic [31:0] fp_nan(input logic fp16);
    return fp16 ? H_QNAN : S_QNAN;
  endfunction

  function automatic logic [31:0] fp_inf(input logic sign, input logic fp16);
    return fp16 ? (H_INF | {16'b0, sign, 15'b0}) : (S_INF | {sign, 31'b0});
  endfunction

  function automatic logic [31:0] fp_zero(input logic sign, input logic fp16);
    return fp16 ? {16'b0, sign, 15'b0} : {sign, 31'b0};
  endfunction

endpackage

// File: rtl/fp_round_pack.sv
// Round-to-nearest-even and pack a normalised significand into FP16 or FP32.
// Latency: combinational.
// Backpressure: none; output follows inputs.
module fp_round_pack
  import fp_alu_pkg::*;
(
  input  logic        sign,
  input  logic [9:0]  expo,        // unbiased, two's complement
  input  logic [26:0] sig,         // [26] hidden one, fraction below, then G/R/S
  input  logic        fp16,
  output logic [31:0] packed_val,
  output logic        ovf,
  output logic        unf,
  output logic        inx
);

  logic [22:0]       frac;
  logic [22:0]       frac_r;
  logic              g;
  logic              st;
  logic              all1;
  logic              rnd_up;
  logic [9:0]        bias;
  logic signed [9:0] biased;
  logic signed [9:0] emax;

  // Pick the rounding point for the format, round, then range-check the exponent.
  always_comb begin
    if (fp16) begin
      frac = {13'b0, sig[25:16]};
      g    = sig[15];
      st   = |sig[14:0];
      all1 = &sig[25:16];
      bias = H_BIAS;
      emax = 10'sd31;
    end else begin
      frac = sig[25:3];
      g    = sig[2];
      st   = |sig[1:0];
      all1 = &sig[25:3];
      bias = S_BIAS;
      emax = 10'sd255;
    end
    rnd_up = g & (st | frac[0]);
    frac_r = frac + {22'b0, rnd_up};
    // An all-ones fraction rounding up wraps to zero and bumps the exponent.
    biased = $signed(expo + bias + {9'b0, rnd_up & all1});

    packed_val = '0;
    ovf        = 1'b0;
    unf        = 1'b0;
    inx        = g | st;
    if (!sig[26]) begin
      // A non-normalised (zero) significand packs as signed zero.
      packed_val = fp_zero(sign, fp16);
      inx        = 1'b0;
    end else if (biased >= emax) begin
      packed_val = fp_inf(sign, fp16);
      ovf        = 1'b1;
      inx        = 1'b1;
    end else if (biased <= 10'sd0) begin
      packed_val = fp_zero(sign, fp16);
      unf        = 1'b1;
      inx        = 1'b1;
    end else if (fp16) begin
      packed_val = {16'b0, sign, biased[4:0], frac_r[9:0]};
    end else begin
      packed_val = {sign, biased[7:0], frac_r[22:0]};
    end
  end

endmodule

// File: rtl/fp_alu_if.sv
// Single-issue FP16/FP32 add/sub/mul/div unit with registered result and IEEE flags.
// Latency: 1 cycle from start edge to result/flags/valid_out.
// Backpressure: none; accepts an op every cycle start is high, valid_out is a strobe.
module fp_alu_if
  import fp_alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        mode_fp,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic [31:0] result,
  output logic [4:0]  flags,
  output logic        valid_out
);

  localparam logic [4:0] NV_ONLY = 5'(1 << FLG_NV);
  localparam logic [4:0] DZ_ONLY = 5'(1 << FLG_DZ);

  fp_operand_t ua;
  fp_operand_t ub;
  logic        sx;
  logic [31:0] raw_a;
  logic [31:0] raw_b;

  // add/sub datapath
  logic        a_big;
  logic        eff_sub;
  logic        big_sign;
  logic [9:0]  big_expo;
  logic [23:0] big_sig;
  logic [9:0]  sml_expo;
  logic [23:0] sml_sig;
  logic [9:0]  ediff;
  logic [4:0]  sh;
  logic [53:0] sh_tmp;
  logic [26:0] sml_al;
  logic [27:0] big_m;
  logic [27:0] sum;
  logic [4:0]  lz;
  logic        found;
  logic [26:0] add_norm;
  logic [9:0]  add_expo;

  // mul/div datapath
  logic [47:0] prod;
  logic [26:0] mul_norm;
  logic [9:0]  mul_expo;
  logic [25:0] rem;
  logic [27:0] q;
  logic        div_sticky;
  logic [26:0] div_norm;
  logic [9:0]  div_expo;

  // rounder interface and next-state values
  logic        rp_sign;
  logic [9:0]  rp_expo;
  logic [26:0] rp_sig;
  logic [31:0] rp_val;
  logic        rp_ovf;
  logic        rp_unf;
  logic        rp_inx;
  logic [31:0] res_nxt;
  logic [4:0]  flg_nxt;

  assign ua    = fp_unpack(op_a, mode_fp);
  assign sx    = ua.sign ^ ub.sign;
  assign raw_a = mode_fp ? {16'b0, ua.sign, op_a[14:0]} : {ua.sign, op_a[30:0]};
  assign raw_b = mode_fp ? {16'b0, ub.sign, op_b[14:0]} : {ub.sign, op_b[30:0]};

  // Subtraction is addition with B's sign inverted.
  always_comb begin
    ub      = fp_unpack(op_b, mode_fp);
    ub.sign = ub.sign ^ (op_code == OP_SUB);
  end

  // Add: order by magnitude, align with sticky, add/sub, renormalise.
  always_comb begin
    a_big    = ($signed(ua.expo) > $signed(ub.expo)) ||
               ((ua.expo == ub.expo) && (ua.sig >= ub.sig));
    big_sign = a_big ? ua.sign : ub.sign;
    big_expo = a_big ? ua.expo : ub.expo;
    big_sig  = a_big ? ua.sig  : ub.sig;
    sml_expo = a_big ? ub.expo : ua.expo;
    sml_sig  = a_big ? ub.sig  : ua.sig;
    eff_sub  = ua.sign ^ ub.sign;
    ediff    = big_expo - sml_expo;
    // Beyond 30 the smaller operand only ever contributes a sticky bit.
    sh       = (ediff > 10'd30) ? 5'd30 : ediff[4:0];
    sh_tmp   = {sml_sig, 30'b0} >> sh;
    sml_al   = sh_tmp[53:27] | {26'b0, |sh_tmp[26:0]};
    big_m    = {1'b0, big_sig, 3'b000};
    sum      = eff_sub ? (big_m - {1'b0, sml_al}) : (big_m + {1'b0, sml_al});
    lz       = 5'd0;
    found    = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found && sum[i]) begin
        lz    = 5'(26 - i);
        found = 1'b1;
      end
    end
    if (sum[27]) begin
      add_norm = sum[27:1] | {26'b0, sum[0]};
      add_expo = big_expo + 10'd1;
    end else begin
      add_norm = sum[26:0] << lz;
      add_expo = big_expo - {5'b0, lz};
    end
  end

  // Mul: full 24x24 product, normalise the [1,4) result by one position.
  always_comb begin
    prod = {24'b0, ua.sig} * {24'b0, ub.sig};
    if (prod[47]) begin
      mul_norm = {prod[47:22], |prod[21:0]};
      mul_expo = ua.expo + ub.expo + 10'd1;
    end else begin
      mul_norm = {prod[46:21], |prod[20:0]};
      mul_expo = ua.expo + ub.expo;
    end
  end

  // Div: restoring division yields 28 quotient bits; the remainder forms sticky.
  always_comb begin
    rem = {2'b00, ua.sig};
    q   = '0;
    for (int i = 27; i >= 0; i--) begin
      if (rem >= {2'b00, ub.sig}) begin
        q[i] = 1'b1;
        rem  = rem - {2'b00, ub.sig};
      end
      rem = {rem[24:0], 1'b0};
    end
    div_sticky = |rem;
    if (q[27]) begin
      div_norm = {q[27:2], q[1] | q[0] | div_sticky};
      div_expo = ua.expo - ub.expo;
    end else begin
      div_norm = {q[26:1], q[0] | div_sticky};
      div_expo = ua.expo - ub.expo - 10'd1;
    end
  end

  // Route the active datapath into the shared rounder.
  always_comb begin
    rp_sign = big_sign;
    rp_expo = add_expo;
    rp_sig  = add_norm;
    if (op_code == OP_MUL) begin
      rp_sign = sx;
      rp_expo = mul_expo;
      rp_sig  = mul_norm;
    end else if (op_code == OP_DIV) begin
      rp_sign = sx;
      rp_expo = div_expo;
      rp_sig  = div_norm;
    end
  end

  fp_round_pack u_round_pack (
    .sign       (rp_sign),
    .expo       (rp_expo),
    .sig        (rp_sig),
    .fp16       (mode_fp),
    .packed_val (rp_val),
    .ovf        (rp_ovf),
    .unf        (rp_unf),
    .inx        (rp_inx)
  );

  // Special operands override the rounded datapath result.
  always_comb begin
    res_nxt         = rp_val;
    flg_nxt         = '0;
    flg_nxt[FLG_OF] = rp_ovf;
    flg_nxt[FLG_UF] = rp_unf;
    flg_nxt[FLG_NX] = rp_inx;
    if (op_code == OP_MUL) begin
      if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_zero) || (ua.is_zero && ub.is_inf)) begin
        res_nxt = fp_nan(mode_fp);
        flg_nxt = NV_ONLY;
      end else if (ua.is_inf || ub.is_inf) begin
        res_nxt = fp_inf(sx, mode_fp);
        flg_nxt = '0;
      end else if (ua.is_zero || ub.is_zero) begin
        res_nxt = fp_zero(sx, mode_fp);
        flg_nxt = '0;
      end
    end else if (op_code == OP_DIV) begin
      if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf) || (ua.is_zero && ub.is_zero)) begin
        res_nxt = fp_nan(mode_fp);
        flg_nxt = NV_ONLY;
      end else if (ua.is_inf) begin
        res_nxt = fp_inf(sx, mode_fp);
        flg_nxt = '0;
      end else if (ub.is_inf) begin
        res_nxt = fp_zero(sx, mode_fp);
        flg_nxt = '0;
      end else if (ub.is_zero) begin
        res_nxt = fp_inf(sx, mode_fp);
        flg_nxt = DZ_ONLY;
      end else if (ua.is_zero) begin
        res_nxt = fp_zero(sx, mode_fp);
        flg_nxt = '0;
      end
    end else begin
      if (ua.is_nan || ub.is_nan || (ua.is_inf && ub.is_inf && eff_sub)) begin
        res_nxt = fp_nan(mode_fp);
        flg_nxt = NV_ONLY;
      end else if (ua.is_inf) begin
        res_nxt = fp_inf(ua.sign, mode_fp);
        flg_nxt = '0;
      end else if (ub.is_inf) begin
        res_nxt = fp_inf(ub.sign, mode_fp);
        flg_nxt = '0;
      end else if (ua.is_zero && ub.is_zero) begin
        res_nxt = fp_zero(ua.sign & ub.sign, mode_fp);
        flg_nxt = '0;
      end else if (ua.is_zero) begin
        res_nxt = raw_b;
        flg_nxt = '0;
      end else if (ub.is_zero) begin
        res_nxt = raw_a;
        flg_nxt = '0;
      end else if (sum == 28'd0) begin
        // Exact cancellation always yields +0.
        res_nxt = fp_zero(1'b0, mode_fp);
        flg_nxt = '0;
      end
    end
  end

  // Output registers: capture on start, strobe valid_out, hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      result    <= '0;
      flags     <= '0;
      valid_out <= 1'b0;
    end else begin
      valid_out <= start;
      if (start) begin
        result <= res_nxt;
        flags  <= flg_nxt;
      end
    end
  end

endmodule

// File: tb/tb_fp_alu_if.sv
module tb_fp_alu_if;

  localparam logic [1:0] ADD = 2'b00;
  localparam logic [1:0] SUB = 2'b01;
  localparam logic [1:0] MUL = 2'b10;
  localparam logic [1:0] DIV = 2'b11;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        mode_fp;
  logic [1:0]  op_code;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [31:0] result;
  logic [4:0]  flags;
  logic        valid_out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  fp_alu_if dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode_fp   (mode_fp),
    .op_code   (op_code),
    .op_a      (op_a),
    .op_b      (op_b),
    .result    (result),
    .flags     (flags),
    .valid_out (valid_out)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic [31:0] er, input logic [4:0] ef,
                           input logic ev);
    chk({tag, " result"}, result, er);
    chk({tag, " flags"}, {27'b0, flags}, {27'b0, ef});
    chk({tag, " valid"}, {31'b0, valid_out}, {31'b0, ev});
  endtask

  // Drive one op at the falling edge, sample 1 ns after the capturing edge.
  // In FP16 mode the upper operand halves carry junk that must be ignored.
  task automatic run(input string tag, input logic m, input logic [1:0] op,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] er, input logic [4:0] ef, input bit keep);
    @(negedge clk);
    start   = 1'b1;
    mode_fp = m;
    op_code = op;
    op_a    = m ? {16'($urandom), a[15:0]} : a;
    op_b    = m ? {16'($urandom), b[15:0]} : b;
    @(posedge clk);
    #1;
    if (!keep) begin
      start = 1'b0;
      op_a  = $urandom;
      op_b  = $urandom;
    end
    check_out(tag, er, ef, 1'b1);
  endtask

  task automatic idle(input string tag, input logic [31:0] er, input logic [4:0] ef);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #1;
    check_out(tag, er, ef, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b0; start = 1'b0; mode_fp = 1'b0; op_code = ADD; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check_out("reset", 32'h0, 5'b00000, 1'b0);
    @(negedge clk);
    rst = 1'b1;

    // FP16 add / sub
    run("add16 1+2",      1'b1, ADD, 32'h3C00, 32'h4000, 32'h0000_4200, 5'b00000, 1'b0);
    idle("hold",          32'h0000_4200, 5'b00000);
    run("add16 4+3",      1'b1, ADD, 32'h4400, 32'h4200, 32'h0000_4700, 5'b00000, 1'b0);
    run("add16 32+8",     1'b1, ADD, 32'h5000, 32'h4800, 32'h0000_5100, 5'b00000, 1'b0);
    run("add16 -1+1",     1'b1, ADD, 32'hBC00, 32'h3C00, 32'h0000_0000, 5'b00000, 1'b0);
    run("sub16 2-1",      1'b1, SUB, 32'h4000, 32'h3C00, 32'h0000_3C00, 5'b00000, 1'b0);
    run("sub16 -1-1",     1'b1, SUB, 32'hBC00, 32'h3C00, 32'h0000_C000, 5'b00000, 1'b0);
    run("sub16 inf-inf",  1'b1, SUB, 32'h7C00, 32'h7C00, 32'h0000_7E00, 5'b10000, 1'b0);
    run("add16 max+2",    1'b1, ADD, 32'h7BFF, 32'h4000, 32'h0000_7BFF, 5'b00001, 1'b0);

    // FP16 mul
    run("mul16 4*3",      1'b1, MUL, 32'h4400, 32'h4200, 32'h0000_4A00, 5'b00000, 1'b0);
    run("mul16 32*8",     1'b1, MUL, 32'h5000, 32'h4800, 32'h0000_5C00, 5'b00000, 1'b0);
    run("mul16 -1*1",     1'b1, MUL, 32'hBC00, 32'h3C00, 32'h0000_BC00, 5'b00000, 1'b0);
    run("mul16 inf*0",    1'b1, MUL, 32'h7C00, 32'h0000, 32'h0000_7E00, 5'b10000, 1'b0);
    run("mul16 inf*inf",  1'b1, MUL, 32'h7C00, 32'h7C00, 32'h0000_7C00, 5'b00000, 1'b0);
    run("mul16 tiny",     1'b1, MUL, 32'h0400, 32'h3800, 32'h0000_0000, 5'b00011, 1'b0);
    run("mul16 -tiny",    1'b1, MUL, 32'h8400, 32'h3800, 32'h0000_8000, 5'b00011, 1'b0);

    // FP16 div
    run("div16 1/2",      1'b1, DIV, 32'h3C00, 32'h4000, 32'h0000_3800, 5'b00000, 1'b0);
    run("div16 3/2",      1'b1, DIV, 32'h4200, 32'h4000, 32'h0000_3E00, 5'b00000, 1'b0);
    run("div16 8/2",      1'b1, DIV, 32'h4800, 32'h4000, 32'h0000_4400, 5'b00000, 1'b0);
    run("div16 0/1",      1'b1, DIV, 32'h0000, 32'h3C00, 32'h0000_0000, 5'b00000, 1'b0);
    run("div16 1/0",      1'b1, DIV, 32'h3C00, 32'h0000, 32'h0000_7C00, 5'b01000, 1'b0);
    run("div16 inf/inf",  1'b1, DIV, 32'h7C00, 32'h7C00, 32'h0000_7E00, 5'b10000, 1'b0);
    run("div16 0/0",      1'b1, DIV, 32'h0000, 32'h0000, 32'h0000_7E00, 5'b10000, 1'b0);

    // FP32
    run("add32 1+2",      1'b0, ADD, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 5'b00000, 1'b0);
    run("mul32 max*2",    1'b0, MUL, 32'h7F7F_FFFF, 32'h4000_0000, 32'h7F80_0000, 5'b00101, 1'b0);
    run("add32 nan+1",    1'b0, ADD, 32'h7FC0_0001, 32'h3F80_0000, 32'h7FC0_0000, 5'b10000, 1'b0);

    // Back-to-back: start held high across three mixed ops
    run("b2b add16",      1'b1, ADD, 32'h3C00, 32'h3C00, 32'h0000_4000, 5'b00000, 1'b1);
    run("b2b mul32",      1'b0, MUL, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 5'b00000, 1'b1);
    run("b2b div16 1/3",  1'b1, DIV, 32'h3C00, 32'h4200, 32'h0000_3555, 5'b00001, 1'b0);
    idle("b2b hold",      32'h0000_3555, 5'b00001);

    // Reset asserted during a start cycle: outputs cleared, no strobe
    @(negedge clk);
    start = 1'b1; mode_fp = 1'b1; op_code = ADD; op_a = 32'h3C00; op_b = 32'h3C00;
    #2;
    rst = 1'b0;
    #1;
    check_out("async rst", 32'h0, 5'b00000, 1'b0);
    @(posedge clk);
    #1;
    check_out("rst mid-op", 32'h0, 5'b00000, 1'b0);
    @(negedge clk);
    rst   = 1'b1;
    start = 1'b0;
    @(posedge clk);
    #1;
    check_out("post rst", 32'h0, 5'b00000, 1'b0);
    run("recover add16",  1'b1, ADD, 32'h3C00, 32'h4000, 32'h0000_4200, 5'b00000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
